// File: rtl/multi_cycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes plus halt handling.
// Optional SEQ_TRAP_EN: unsupported types trap in TRAP with a sticky illegal flag, instead of retiring as NOPs.
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ack
// DECODE | latch instr_type
// EXEC   | ALU cycle, pick MEM or WB
// MEM    | data access, wait for dmem_ack
// WB     | register/PC update, count retirement
// HALT   | parked while halt_req is held
// TRAP   | unsupported type, exit by reset only
module multi_cycle_seq #(
    parameter int RETIRED_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           instr_type,
    input  logic                 branch_taken,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 halt_req,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 alu_en,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 halted,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [RETIRED_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [4:0] T_LOAD      = 5'd1;
    localparam logic [4:0] T_STORE     = 5'd2;
    localparam logic [4:0] T_OP        = 5'd3;
    localparam logic [4:0] T_OP_IMM    = 5'd4;
    localparam logic [4:0] T_OP_32     = 5'd5;
    localparam logic [4:0] T_OP_IMM_32 = 5'd6;
    localparam logic [4:0] T_LUI       = 5'd7;
    localparam logic [4:0] T_AUIPC     = 5'd8;
    localparam logic [4:0] T_JAL       = 5'd9;
    localparam logic [4:0] T_JALR      = 5'd10;
    localparam logic [4:0] T_BRANCH    = 5'd11;

    logic [2:0]           state_q, state_d;
    logic [4:0]           type_q;
    logic [RETIRED_W-1:0] retired_q;
    logic                 is_store, is_mem, is_wb_class, writes_rf, takes_target;

    always_comb begin
        is_store     = (type_q == T_STORE);
        is_mem       = (type_q == T_LOAD) || is_store;
        is_wb_class  = type_q inside {T_OP, T_OP_IMM, T_OP_32, T_OP_IMM_32, T_LUI,
                                      T_AUIPC, T_JAL, T_JALR, T_BRANCH};
        writes_rf    = type_q inside {T_LOAD, T_OP, T_OP_IMM, T_OP_32, T_OP_IMM_32,
                                      T_LUI, T_AUIPC, T_JAL, T_JALR};
        takes_target = (type_q == T_JAL) || (type_q == T_JALR) ||
                       ((type_q == T_BRANCH) && branch_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q    <= 5'd0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE) type_q <= instr_type;
            if (state_q == S_WB)     retired_q <= retired_q + {{(RETIRED_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SEQ_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)                                                illegal_q <= 1'b0;
        else if (state_q == S_EXEC && !is_mem && !is_wb_class) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem)           state_d = S_MEM;
                else if (is_wb_class) state_d = S_WB;
`ifdef SEQ_TRAP_EN
                else                  state_d = S_TRAP;
`else
                else                  state_d = S_WB;   // unsupported type retires as a NOP
`endif
            end
            S_MEM:    if (dmem_ack) state_d = S_WB;
            S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT:   state_d = halt_req ? S_HALT : S_FETCH;
`ifdef SEQ_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`else
            S_TRAP:   state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_EXEC:  alu_en = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            S_WB: begin
                pc_we  = 1'b1;
                rf_we  = writes_rf;
                pc_sel = takes_target;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Self-checking bench for multi_cycle_seq: per-cycle state/output checks and a WB scoreboard.
module tb_multi_cycle_seq;

    localparam logic [4:0] T_LOAD = 5'd1, T_STORE = 5'd2, T_OP = 5'd3, T_OP_IMM = 5'd4,
                           T_OP_32 = 5'd5, T_OP_IMM_32 = 5'd6, T_LUI = 5'd7, T_AUIPC = 5'd8,
                           T_JAL = 5'd9, T_JALR = 5'd10, T_BRANCH = 5'd11;

    logic        clk = 1'b0;
    logic        rst, branch_taken, imem_ack, dmem_ack, halt_req;
    logic [4:0]  instr_type;
    logic        imem_req, ir_we, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, halted, illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    multi_cycle_seq #(.RETIRED_W(32)) dut (
        .clk(clk), .rst(rst), .instr_type(instr_type), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt_req(halt_req),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_en(alu_en), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .halted(halted), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rf;
        logic psel;
    } wb_exp_t;

    wb_exp_t     sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [12:0] got, exp;

    // {state, imem_req, ir_we, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, halted, illegal}
    function automatic logic [12:0] obs();
        return {state, imem_req, ir_we, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, halted, illegal};
    endfunction

    task automatic run_instr(input logic [4:0] t, input logic taken, input int iwait,
                             input int dwait, input logic hreq_exec, input logic hreq_wb);
        logic    is_store, is_mem;
        wb_exp_t e;
        is_store = (t == T_STORE);
        is_mem   = (t == T_LOAD) || is_store;
        e.rf     = t inside {T_LOAD, T_OP, T_OP_IMM, T_OP_32, T_OP_IMM_32, T_LUI, T_AUIPC, T_JAL, T_JALR};
        e.psel   = (t == T_JAL) || (t == T_JALR) || ((t == T_BRANCH) && taken);
        sbq.push_back(e);
        for (int i = 0; i <= iwait; i++) begin
            @(negedge clk);
            instr_type = t; imem_ack = (i == iwait); dmem_ack = 1'b1;
            halt_req = 1'b0; branch_taken = 1'b0;
            #1;
            got = obs(); exp = {3'd0, 1'b1, imem_ack, 8'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL fetch t=%0d cyc=%0d: got %h expected %h", t, i, got, exp);
            end
            if (i == 0) begin
                vectors++;
                if (retired !== exp_retired) begin
                    miscompares++; $display("FAIL retired: got %0d expected %0d", retired, exp_retired);
                end
            end
        end
        @(negedge clk);
        imem_ack = 1'b1; dmem_ack = 1'b1; halt_req = hreq_exec;
        #1;
        got = obs(); exp = {3'd1, 10'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL decode t=%0d: got %h expected %h", t, got, exp);
        end
        @(negedge clk);
        instr_type = ~t;
        #1;
        got = obs(); exp = {3'd2, 10'h020};
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL exec t=%0d: got %h expected %h", t, got, exp);
        end
        if (is_mem) begin
            for (int j = 0; j <= dwait; j++) begin
                @(negedge clk);
                imem_ack = 1'b1; halt_req = 1'b1; dmem_ack = (j == dwait);
                #1;
                got = obs(); exp = {3'd3, 2'b00, 1'b1, is_store, 6'b0};
                vectors++;
                if (got !== exp) begin
                    miscompares++; $display("FAIL mem t=%0d cyc=%0d: got %h expected %h", t, j, got, exp);
                end
            end
        end
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = taken; halt_req = hreq_wb;
        #1;
        e = sbq.pop_front();
        got = obs(); exp = {3'd4, 5'b0, e.rf, 1'b1, e.psel, 2'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL wb t=%0d: got %h expected %h", t, got, exp);
        end
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; instr_type = 5'd3; imem_ack = 1'b1; dmem_ack = 1'b1; halt_req = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        #1;
        got = obs(); exp = {3'd0, 1'b1, 1'b1, 8'b0};
        vectors++;
        if (got !== exp || retired !== 32'd0) begin
            miscompares++; $display("FAIL reset: got %h/%0d expected %h/0", got, retired, exp);
        end
        rst = 1'b0; imem_ack = 1'b0; halt_req = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_op();
        run_instr(T_OP, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_store();
        run_instr(T_LOAD, 1'b0, 3, 2, 1'b0, 1'b0);
        run_instr(T_STORE, 1'b0, 3, 2, 1'b0, 1'b0);
    endtask

    task automatic test_branch_jump();
        run_instr(T_BRANCH, 1'b0, 0, 0, 1'b0, 1'b0);
        run_instr(T_BRANCH, 1'b1, 1, 0, 1'b0, 1'b0);
        run_instr(T_JAL, 1'b0, 0, 0, 1'b0, 1'b0);
        run_instr(T_JALR, 1'b1, 0, 0, 1'b0, 1'b0);
        run_instr(T_LUI, 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        run_instr(T_OP_IMM, 1'b0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            halt_req = (k < 2); imem_ack = 1'b1; dmem_ack = 1'b1;
            #1;
            got = obs(); exp = {3'd5, 8'b0, 1'b1, 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL halt cyc=%0d: got %h expected %h", k, got, exp);
            end
        end
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0) begin
            miscompares++; $display("FAIL halt_exit: got state %0d expected 0", state);
        end
        run_instr(T_OP_32, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_unsupported();
`ifdef SEQ_TRAP_EN
        @(negedge clk);
        instr_type = 5'd0; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            halt_req = k[0]; imem_ack = 1'b1; dmem_ack = 1'b1;
            #1;
            got = obs(); exp = {3'd6, 9'b0, 1'b1};
            vectors++;
            if (got !== exp || retired !== exp_retired) begin
                miscompares++;
                $display("FAIL trap cyc=%0d: got %h/%0d expected %h/%0d", k, got, retired, exp, exp_retired);
            end
        end
        test_reset();
`else
        run_instr(5'd0, 1'b1, 1, 0, 1'b0, 1'b0);
        run_instr(5'd31, 1'b1, 0, 0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++)
            run_instr(5'($urandom_range(1, 11)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk);
        instr_type = T_LOAD; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        got = obs(); exp = {3'd3, 2'b00, 1'b1, 7'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL pre_rst_mem: got %h expected %h", got, exp);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got = obs(); exp = {3'd0, 1'b1, 9'b0};
        vectors++;
        if (got !== exp || retired !== 32'd0) begin
            miscompares++; $display("FAIL rst_mid_mem: got %h/%0d expected %h/0", got, retired, exp);
        end
        exp_retired = 32'd0;
        run_instr(T_AUIPC, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++; $display("FAIL retired_final: got %0d expected %0d", retired, exp_retired);
        end
    endtask

    initial begin
        rst = 1'b1; instr_type = 5'd0; branch_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
        test_reset();
        test_op();
        test_load_store();
        test_branch_jump();
        test_halt();
        test_unsupported();
        test_back_to_back();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
